// File: rtl/upgrade_pkg.sv
// Shared constants, state encoding and LFSR helper for the upgrade spawner slice.
package upgrade_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_PLACE  = 2'd2;
  localparam state_t ST_ACTIVE = 2'd3;

  // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam int DEF_SPAWN_DELAY    = 300;
  localparam int DEF_ACTIVE_TIMEOUT = 600;
  localparam int DEF_BOOST_FRAMES   = 480;
  localparam int DEF_X_MIN          = 40;
  localparam int DEF_X_MAX          = 600;
  localparam int DEF_Y_MIN          = 40;
  localparam int DEF_Y_MAX          = 440;
  localparam int DEF_UPGRADE_SIZE   = 8;

  localparam logic [2:0] PLACE_MAX_RETRY = 3'd7;
  localparam int         BLINK_WINDOW    = 120;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/upgrade_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; advances every frame and exposes its full state.
module upgrade_lfsr import upgrade_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        frame_clk,
  input  logic        Reset,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/upgrade_spawner.sv
// Upgrade spawner: places pickups, arms the collector and runs per-player speed boosts.
// Optional build macro UPGRADE_BLINK_EN blinks the sprite shortly before despawn.
module upgrade_spawner import upgrade_pkg::*; #(
  parameter int          SPAWN_DELAY    = DEF_SPAWN_DELAY,
  parameter int          ACTIVE_TIMEOUT = DEF_ACTIVE_TIMEOUT,
  parameter int          BOOST_FRAMES   = DEF_BOOST_FRAMES,
  parameter int          X_MIN          = DEF_X_MIN,
  parameter int          X_MAX          = DEF_X_MAX,
  parameter int          Y_MIN          = DEF_Y_MIN,
  parameter int          Y_MAX          = DEF_Y_MAX,
  parameter int          UPGRADE_SIZE   = DEF_UPGRADE_SIZE,
  parameter logic [15:0] LFSR_SEED      = LFSR_DEFAULT_SEED
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic       collected,
  input  logic       speed_1_upgraded,
  input  logic       speed_2_upgraded,
  output logic [9:0] UpgradeX,
  output logic [9:0] UpgradeY,
  output logic [9:0] Upgrade_Size,
  output logic       upgrade_visible,
  output logic       collector_clear,
  output logic       boost_1_active,
  output logic       boost_2_active,
  output logic [7:0] spawn_count
);

  localparam int WAIT_W  = $clog2(SPAWN_DELAY + 1);
  localparam int ACT_W   = $clog2(ACTIVE_TIMEOUT + 1);
  localparam int BOOST_W = $clog2(BOOST_FRAMES + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(SPAWN_DELAY - 1);
  localparam logic [ACT_W-1:0]   ACT_LOAD   = ACT_W'(ACTIVE_TIMEOUT - 1);
  localparam logic [BOOST_W-1:0] BOOST_LOAD = BOOST_W'(BOOST_FRAMES);
  localparam logic [10:0] X_LO  = 11'(X_MIN);
  localparam logic [10:0] X_HI  = 11'(X_MAX);
  localparam logic [10:0] Y_LO  = 11'(Y_MIN);
  localparam logic [10:0] Y_HI  = 11'(Y_MAX);
  localparam logic [9:0]  X_MID = 10'((X_MIN + X_MAX) / 2);
  localparam logic [9:0]  Y_MID = 10'((Y_MIN + Y_MAX) / 2);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [ACT_W-1:0]   act_q, act_d;
  logic [2:0]         retry_q, retry_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic [7:0]         spawn_q, spawn_d;
  logic [BOOST_W-1:0] boost1_q, boost1_d, boost2_q, boost2_d;
  logic               spd1_prev_q, spd2_prev_q;

  logic [15:0] lfsr_s;
  logic [10:0] cand_x_s, cand_y_s;
  logic        cand_ok_s;

  upgrade_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .state_o   (lfsr_s)
  );

  // Compare in 11 bits so a full-range bound never degenerates to a constant test.
  assign cand_x_s  = {1'b0, lfsr_s[9:0]};
  assign cand_y_s  = {1'b0, lfsr_s[15:6]};
  assign cand_ok_s = (cand_x_s >= X_LO) && (cand_x_s <= X_HI) &&
                     (cand_y_s >= Y_LO) && (cand_y_s <= Y_HI);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    act_d   = act_q;
    retry_d = retry_q;
    x_d     = x_q;
    y_d     = y_q;
    spawn_d = spawn_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
          wait_d  = WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_q == {WAIT_W{1'b0}}) begin
            state_d = ST_PLACE;
            retry_d = 3'd0;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        ST_PLACE: begin
          if (cand_ok_s || (retry_q == PLACE_MAX_RETRY)) begin
            state_d = ST_ACTIVE;
            act_d   = ACT_LOAD;
            x_d     = cand_ok_s ? cand_x_s[9:0] : X_MID;
            y_d     = cand_ok_s ? cand_y_s[9:0] : Y_MID;
            spawn_d = (spawn_q == 8'hFF) ? spawn_q : spawn_q + 8'd1;
          end else begin
            retry_d = retry_q + 3'd1;
          end
        end
        ST_ACTIVE: begin
          if (collected || (act_q == {ACT_W{1'b0}})) begin
            state_d = ST_WAIT;
            wait_d  = WAIT_LOAD;
          end else begin
            act_d = act_q - ACT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A rising pickup flag reloads the boost to full; otherwise it drains to zero.
  always_comb begin
    boost1_d = boost1_q;
    boost2_d = boost2_q;
    if (speed_1_upgraded && !spd1_prev_q)  boost1_d = BOOST_LOAD;
    else if (boost1_q != {BOOST_W{1'b0}})  boost1_d = boost1_q - BOOST_W'(1);
    else                                   boost1_d = boost1_q;
    if (speed_2_upgraded && !spd2_prev_q)  boost2_d = BOOST_LOAD;
    else if (boost2_q != {BOOST_W{1'b0}})  boost2_d = boost2_q - BOOST_W'(1);
    else                                   boost2_d = boost2_q;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= {WAIT_W{1'b0}};
      act_q       <= {ACT_W{1'b0}};
      retry_q     <= 3'd0;
      x_q         <= X_MID;
      y_q         <= Y_MID;
      spawn_q     <= 8'd0;
      boost1_q    <= {BOOST_W{1'b0}};
      boost2_q    <= {BOOST_W{1'b0}};
      spd1_prev_q <= 1'b0;
      spd2_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      act_q       <= act_d;
      retry_q     <= retry_d;
      x_q         <= x_d;
      y_q         <= y_d;
      spawn_q     <= spawn_d;
      boost1_q    <= boost1_d;
      boost2_q    <= boost2_d;
      spd1_prev_q <= speed_1_upgraded;
      spd2_prev_q <= speed_2_upgraded;
    end
  end

  assign UpgradeX        = x_q;
  assign UpgradeY        = y_q;
  assign Upgrade_Size    = 10'(UPGRADE_SIZE);
  assign spawn_count     = spawn_q;
  assign collector_clear = (state_q != ST_ACTIVE);
  assign boost_1_active  = (boost1_q != {BOOST_W{1'b0}});
  assign boost_2_active  = (boost2_q != {BOOST_W{1'b0}});

`ifdef UPGRADE_BLINK_EN
  logic [31:0] act_ext_s;
  assign act_ext_s       = 32'(act_q);
  assign upgrade_visible = (state_q == ST_ACTIVE) &&
                           ((act_ext_s < 32'(BLINK_WINDOW)) ? act_ext_s[3] : 1'b1);
`else
  assign upgrade_visible = (state_q == ST_ACTIVE);
`endif

endmodule

// File: tb/tb_upgrade_spawner.sv
// Self-checking bench: directed scenarios then random stimulus against a frame-level model.
module tb_upgrade_spawner;

  localparam int SD = 4;
  localparam int AT = 10;
  localparam int BF = 5;

  localparam int PH_IDLE   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_PLACE  = 2;
  localparam int PH_ACTIVE = 3;

  logic Reset, frame_clk, enable, collected, speed_1_upgraded, speed_2_upgraded;
  logic [9:0] x1, y1, sz1, x2, y2, sz2;
  logic       vis1, clr1, b11, b21, vis2, clr2, b12, b22;
  logic [7:0] cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  // Model state: phase, frames spent in phase, position, spawn count, LFSR per instance.
  int          m_ph[2], m_t[2], m_x[2], m_y[2], m_sp[2];
  int          m_xmin[2], m_xmax[2];
  int unsigned m_l[2];
  int          frame, end1, end2;
  bit          p1, p2;

  upgrade_spawner #(.SPAWN_DELAY(SD), .ACTIVE_TIMEOUT(AT), .BOOST_FRAMES(BF)) dut1 (
    .Reset(Reset), .frame_clk(frame_clk), .enable(enable), .collected(collected),
    .speed_1_upgraded(speed_1_upgraded), .speed_2_upgraded(speed_2_upgraded),
    .UpgradeX(x1), .UpgradeY(y1), .Upgrade_Size(sz1), .upgrade_visible(vis1),
    .collector_clear(clr1), .boost_1_active(b11), .boost_2_active(b21), .spawn_count(cnt1)
  );

  upgrade_spawner #(.SPAWN_DELAY(SD), .ACTIVE_TIMEOUT(AT), .BOOST_FRAMES(BF),
                    .X_MIN(1023), .X_MAX(1023)) dut2 (
    .Reset(Reset), .frame_clk(frame_clk), .enable(enable), .collected(collected),
    .speed_1_upgraded(speed_1_upgraded), .speed_2_upgraded(speed_2_upgraded),
    .UpgradeX(x2), .UpgradeY(y2), .Upgrade_Size(sz2), .upgrade_visible(vis2),
    .collector_clear(clr2), .boost_1_active(b12), .boost_2_active(b22), .spawn_count(cnt2)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned lfsr_step(input int unsigned v);
    int unsigned fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 32'd1;
    return ((v << 1) | fb) & 32'hFFFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = PH_IDLE;
      m_t[i]  = 0;
      m_x[i]  = (m_xmin[i] + m_xmax[i]) / 2;
      m_y[i]  = (40 + 440) / 2;
      m_sp[i] = 0;
      m_l[i]  = 32'hACE1;
    end
    frame = 0; end1 = 0; end2 = 0; p1 = 1'b0; p2 = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit col, input bit s1, input bit s2);
    int cx, cy;
    bit ok;
    frame++;
    if (s1 && !p1) end1 = frame + BF;
    if (s2 && !p2) end2 = frame + BF;
    p1 = s1; p2 = s2;
    for (int i = 0; i < 2; i++) begin
      cx = int'(m_l[i] & 32'd1023);
      cy = int'((m_l[i] >> 6) & 32'd1023);
      if (!en) m_ph[i] = PH_IDLE;
      else if (m_ph[i] == PH_IDLE) begin
        m_ph[i] = PH_WAIT; m_t[i] = 0;
      end else if (m_ph[i] == PH_WAIT) begin
        if (m_t[i] == SD - 1) begin m_ph[i] = PH_PLACE; m_t[i] = 0; end
        else m_t[i]++;
      end else if (m_ph[i] == PH_PLACE) begin
        ok = (cx >= m_xmin[i]) && (cx <= m_xmax[i]) && (cy >= 40) && (cy <= 440);
        if (ok || m_t[i] == 7) begin
          m_x[i]  = ok ? cx : (m_xmin[i] + m_xmax[i]) / 2;
          m_y[i]  = ok ? cy : 240;
          m_ph[i] = PH_ACTIVE; m_t[i] = 0;
          m_sp[i] = (m_sp[i] < 255) ? m_sp[i] + 1 : 255;
        end else m_t[i]++;
      end else begin
        if (col || m_t[i] == AT - 1) begin m_ph[i] = PH_WAIT; m_t[i] = 0; end
        else m_t[i]++;
      end
      m_l[i] = lfsr_step(m_l[i]);
    end
  endtask

  task automatic check_all();
    chk("d1.x", x1, m_x[0]);             chk("d2.x", x2, m_x[1]);
    chk("d1.y", y1, m_y[0]);             chk("d2.y", y2, m_y[1]);
    chk("d1.size", sz1, 8);              chk("d2.size", sz2, 8);
    chk("d1.vis", vis1, m_ph[0] == PH_ACTIVE);
    chk("d2.vis", vis2, m_ph[1] == PH_ACTIVE);
    chk("d1.clr", clr1, m_ph[0] != PH_ACTIVE);
    chk("d2.clr", clr2, m_ph[1] != PH_ACTIVE);
    chk("d1.cnt", cnt1, m_sp[0]);        chk("d2.cnt", cnt2, m_sp[1]);
    chk("d1.b1", b11, frame < end1);     chk("d2.b1", b12, frame < end1);
    chk("d1.b2", b21, frame < end2);     chk("d2.b2", b22, frame < end2);
  endtask

  task automatic step(input bit en, input bit col, input bit s1, input bit s2);
    enable = en; collected = col; speed_1_upgraded = s1; speed_2_upgraded = s2;
    @(posedge frame_clk);
    model_step(en, col, s1, s2);
    @(negedge frame_clk);
    check_all();
  endtask

  task automatic wait_vis1(input string tag);
    int k = 0;
    while (!vis1 && k < 40) begin step(1'b1, 1'b0, 1'b0, 1'b0); k++; end
    chk(tag, vis1, 1);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, ".x1"}, x1, 320);   chk({tag, ".y1"}, y1, 240);
    chk({tag, ".x2"}, x2, 1023);  chk({tag, ".vis"}, vis1, 0);
    chk({tag, ".clr"}, clr1, 1);  chk({tag, ".b1"}, b11, 0);
    chk({tag, ".b2"}, b21, 0);    chk({tag, ".cnt"}, cnt1, 0);
  endtask

  initial begin
    int n, k;
    m_xmin[0] = 40;   m_xmax[0] = 600;
    m_xmin[1] = 1023; m_xmax[1] = 1023;
    Reset = 1'b1; enable = 1'b0; collected = 1'b0;
    speed_1_upgraded = 1'b0; speed_2_upgraded = 1'b0;
    model_reset();
    repeat (2) @(negedge frame_clk);
    reset_values("rst");
    Reset = 1'b0;

    // First spawn: 1 IDLE edge + 4 WAIT edges + 1..8 PLACE edges.
    k = 0;
    while (!vis1 && k < 40) begin step(1'b1, 1'b0, 1'b0, 1'b0); k++; end
    chk("t1.latency_ok", (k >= 6) && (k <= 13), 1);
    chk("t1.vis", vis1, 1);
    chk("t1.clr", clr1, 0);
    chk("t1.cnt", cnt1, 1);
    chk("t1.x_in_range", (x1 >= 40) && (x1 <= 600), 1);
    chk("t1.y_in_range", (y1 >= 40) && (y1 <= 440), 1);

    // Uncollected upgrade is live for exactly AT frames.
    n = 0;
    while (vis1 && n < 40) begin n++; step(1'b1, 1'b0, 1'b0, 1'b0); end
    chk("t2.active_frames", n, AT);
    chk("t2.clr", clr1, 1);
    chk("t2.boost", b11, 0);
    wait_vis1("t2.respawn");
    chk("t2.cnt", cnt1, 2);

    // Pickup on the third ACTIVE frame.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3.vis", vis1, 0);
    chk("t3.b2", b21, 0);
    n = 0;
    while (b11 && n < 20) begin n++; step(1'b1, 1'b0, 1'b0, 1'b0); end
    chk("t3.boost_frames", n, BF);

    // Re-pickup with two frames left extends into one unbroken window.
    wait_vis1("t5.spawn");
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n = 0; k = 0;
    while (b11 && k < 30) begin n++; step(1'b1, 1'b0, k == 3, 1'b0); k++; end
    chk("t5.boost_frames", n, 4 + BF);

    // Disable during ACTIVE while a boost runs, then async reset mid-boost.
    wait_vis1("t6.spawn");
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.vis", vis1, 0);
    chk("t6.clr", clr1, 1);
    chk("t6.b2_running", b21, 1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.b2_expired", b21, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #2 Reset = 1'b1;
    #1 reset_values("t6.async");
    model_reset();
    @(negedge frame_clk);
    Reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
